// File: rtl/note_draw_scheduler.sv
// note_draw_scheduler: draws ten 4x4 note squares per frame request as a stream of VGA pixel writes.
// Define NOTE_DRAW_SKIP_UNCHANGED_EN to skip slots whose note bit matches the previous frame.
module note_draw_scheduler #(
    parameter logic [7:0] X0          = 8'd20,
    parameter logic [6:0] ROW         = 7'd53,
    parameter logic [7:0] PITCH       = 8'd8,
    parameter logic [2:0] NOTE_COLOUR = 3'b100,
    parameter logic [2:0] BG_COLOUR   = 3'b000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       tick,
    input  logic [9:0] notes,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    localparam logic [1:0] IDLE = 2'd0, DRAW = 2'd1, DONE = 2'd2;
    logic [1:0] state_q, state_d;
    logic [3:0] slot_q, slot_d, pix_q, pix_d;
    logic       pending_q, pending_d;
    logic [9:0] frame_notes_q, frame_notes_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       skip, skip_d, start, wrap, last;
`ifdef NOTE_DRAW_SKIP_UNCHANGED_EN
    logic [9:0] prev_notes_q, prev_notes_d;
    assign prev_notes_d = (state_q == DONE) ? frame_notes_q : prev_notes_q;
    assign skip   = frame_notes_q[slot_q] == prev_notes_q[slot_q];
    assign skip_d = frame_notes_d[slot_d] == prev_notes_d[slot_d];
`else
    assign skip   = 1'b0;
    assign skip_d = 1'b0;
`endif
    // Pixel outputs are registered, so they are computed from the next-state slot/pix.
    always_comb begin
        start         = (state_q == IDLE && tick) || (state_q == DONE && (pending_q || tick));
        wrap          = skip || pix_q == 4'd15;
        last          = wrap && slot_q == 4'd9;
        state_d       = state_q;
        slot_d        = slot_q;
        pix_d         = pix_q;
        pending_d     = pending_q;
        frame_notes_d = frame_notes_q;
        if (start) begin
            state_d       = DRAW;
            slot_d        = 4'd0;
            pix_d         = 4'd0;
            pending_d     = 1'b0;
            frame_notes_d = notes;
        end else if (state_q == DONE) begin
            state_d   = IDLE;
            pending_d = 1'b0;
        end else if (state_q == DRAW) begin
            state_d   = last ? DONE : DRAW;
            pending_d = pending_q | tick;
            pix_d     = wrap ? 4'd0 : pix_q + 4'd1;
            slot_d    = last ? 4'd0 : wrap ? slot_q + 4'd1 : slot_q;
        end
        plot_d   = state_d == DRAW && !skip_d;
        x_d      = X0 + 8'(slot_d) * PITCH + {6'd0, pix_d[1:0]};
        y_d      = ROW + {5'd0, pix_d[3:2]};
        colour_d = frame_notes_d[slot_d] ? NOTE_COLOUR : BG_COLOUR;
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= IDLE;
            slot_q        <= 4'd0;
            pix_q         <= 4'd0;
            pending_q     <= 1'b0;
            frame_notes_q <= 10'd0;
            plot_q        <= 1'b0;
            x_q           <= 8'd0;
            y_q           <= 7'd0;
            colour_q      <= 3'd0;
`ifdef NOTE_DRAW_SKIP_UNCHANGED_EN
            prev_notes_q  <= 10'd0;
`endif
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            pix_q         <= pix_d;
            pending_q     <= pending_d;
            frame_notes_q <= frame_notes_d;
            plot_q        <= plot_d;
`ifdef NOTE_DRAW_SKIP_UNCHANGED_EN
            prev_notes_q  <= prev_notes_d;
`endif
            if (plot_d) begin
                x_q      <= x_d;
                y_q      <= y_d;
                colour_q <= colour_d;
            end
        end
    end
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = state_q != IDLE;
    assign done   = state_q == DONE;
endmodule

// File: tb/tb_note_draw_scheduler.sv
// tb_note_draw_scheduler: scoreboard bench; a frame-level model queues the expected pixel stream per frame.
module tb_note_draw_scheduler;
    logic       clk = 1'b0, reset = 1'b1, tick = 1'b0;
    logic [9:0] notes = 10'd0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;
    int tests = 0, fails = 0;
    bit chk_en = 1'b0;
`ifdef NOTE_DRAW_SKIP_UNCHANGED_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    always #10 clk = ~clk;
    note_draw_scheduler dut (
        .CLOCK_50(clk), .reset(reset), .tick(tick), .notes(notes),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );
    typedef struct packed {
        logic       d;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } exp_t;
    exp_t q[$];
    int         m_rem = 0;
    bit         m_pend = 1'b0;
    logic [9:0] m_prev = 10'd0, m_fn = 10'd0;
    function automatic int flen(input logic [9:0] n, input logic [9:0] p);
        int len = 1;
        for (int s = 0; s < 10; s++) len += (SKIP && n[s] == p[s]) ? 1 : 16;
        return len;
    endfunction
    task automatic start_frame(input logic [9:0] n);
        m_fn = n;
        for (int s = 0; s < 10; s++)
            if (!(SKIP && n[s] == m_prev[s]))
                for (int p = 0; p < 16; p++)
                    q.push_back('{1'b0, 8'(20 + 8 * s + p % 4), 7'(53 + p / 4), n[s] ? 3'b100 : 3'b000});
        q.push_back('{1'b1, 8'd0, 7'd0, 3'd0});
        m_rem = flen(n, m_prev);
    endtask
    // Reference model: m_rem counts the busy cycles left in the current frame, the last being DONE.
    always @(posedge clk) begin
        if (reset) begin
            m_rem = 0; m_pend = 1'b0; m_prev = 10'd0;
            q.delete();
        end else if (m_rem == 0) begin
            if (tick) start_frame(notes);
        end else if (m_rem == 1) begin
            m_prev = m_fn;
            if (m_pend || tick) begin
                m_pend = 1'b0;
                start_frame(notes);
            end else m_rem = 0;
        end else begin
            m_rem--;
            m_pend |= tick;
        end
    end
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            tests++;
            if (busy !== (m_rem > 0)) begin
                fails++;
                $display("FAIL busy: got %b, required %b at %0t", busy, m_rem > 0, $time);
            end
            if (plot || done) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: plot=%b done=%b x=%0d y=%0d c=%b, nothing required at %0t", plot, done, x, y, colour, $time);
                end else begin
                    e = q.pop_front();
                    if (plot === done || done !== e.d || (plot && {x, y, colour} !== {e.x, e.y, e.c})) begin
                        fails++;
                        $display("FAIL pixel: got plot=%b done=%b x=%0d y=%0d c=%b, required done=%b x=%0d y=%0d c=%b at %0t",
                                 plot, done, x, y, colour, e.d, e.x, e.y, e.c, $time);
                    end
                end
            end
        end
    end
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input int got, input int req);
        tests++;
        if (got != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask
    task automatic pulse_tick(input logic [9:0] n);
        notes = n; tick = 1'b1;
        cycle();
        tick = 1'b0;
    endtask
    task automatic run_until_idle(output int cyc, output int dn);
        cyc = 0; dn = 0;
        while (busy && cyc < 2000) begin
            cyc++;
            dn += int'(done);
            notes = 10'($urandom);
            cycle();
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask
    initial begin
        int cyc, dn, n;
        cycle();
        cycle();
        check("reset_outputs", int'({plot, busy, done, x, y, colour}), 0);
        reset = 1'b0;
        chk_en = 1'b1;
        pulse_tick(10'h001);
        run_until_idle(cyc, dn);
        check("frame1_busy_len", cyc, flen(10'h001, 10'h000));
        check("frame1_dones", dn, 1);
        pulse_tick(10'h003);
        run_until_idle(cyc, dn);
        check("frame2_busy_len", cyc, flen(10'h003, 10'h001));
        // Three ticks during a frame collapse into one queued frame.
        pulse_tick(10'($urandom));
        cyc = 0; dn = 0;
        while (busy && cyc < 2000) begin
            cyc++;
            dn += int'(done);
            tick = (cyc == 10 || cyc == 50 || cyc == 100);
            notes = done ? 10'h3FF : 10'($urandom);
            cycle();
        end
        tick = 1'b0;
        check("pending_dones", dn, 2);
        // Tick exactly in the DONE cycle restarts without an IDLE gap.
        pulse_tick(10'($urandom));
        n = 0;
        while (!done && n < 400) begin n++; cycle(); end
        check("done_seen", int'(done), 1);
        notes = 10'($urandom); tick = 1'b1;
        cycle();
        tick = 1'b0;
        check("done_tick_restart", int'({busy, done}), 2);
        run_until_idle(cyc, dn);
        check("done_tick_dones", dn, 1);
        // Reset on the 50th plot cycle aborts the frame.
        pulse_tick(10'($urandom));
        n = 0; cyc = 0;
        while (n < 50 && cyc < 400) begin cyc++; n += int'(plot); if (n < 50) cycle(); end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("abort_plot_busy", int'({plot, busy}), 0);
        cycle();
        check("abort_no_done", int'({busy, done}), 0);
        pulse_tick(10'h2A5);
        run_until_idle(cyc, dn);
        check("fresh_frame_len", cyc, flen(10'h2A5, 10'h000));
        for (int i = 0; i < 3000; i++) begin
            tick = ($urandom % 40) == 0;
            notes = 10'($urandom);
            reset = ($urandom % 1200) == 0;
            cycle();
        end
        tick = 1'b0; reset = 1'b0;
        cycle();
        run_until_idle(cyc, dn);
        cycle();
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
